router_pkt_sink: RTL
====================

ROUTER_PKT_SINK -- requirements
Module: router_pkt_sink

Interface
REQ-001 SHALL have parameter PORT_ID, default 2'd0, router output port this sink drains.
REQ-002 SHALL have parameter START_DLY, default 2, idle cycles from vld_out high to first read_enb.
REQ-003 SHALL have parameter TMO, default 32, max consecutive vld_out-low cycles tolerated mid-packet.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 vld_out  in  1  router FIFO non-empty.
REQ-007 data_out  in  8  router FIFO read data, valid one cycle after read_enb sampled high.
REQ-008 read_enb  out  1  FIFO read strobe.
REQ-009 pkt_done  out  1  one-cycle pulse: packet fully received.
REQ-010 pkt_addr  out  2  header[1:0] of last packet.
REQ-011 pkt_len  out  6  header[7:2] of last packet.
REQ-012 parity_err  out  1  last packet XOR-of-all-bytes nonzero; valid with pkt_done.
REQ-013 addr_err  out  1  last header[1:0] != PORT_ID; valid with pkt_done.
REQ-014 trunc_err  out  1  one-cycle pulse: packet aborted on timeout.
REQ-015 pkt_count  out  16  completed packets, wraps 16'hFFFF -> 0.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, DLY, HDR, BODY, DONE.
REQ-018 IDLE -> DLY when vld_out=1; DLY counts START_DLY cycles (0 means skip to HDR next cycle) -> HDR.
REQ-019 read_enb SHALL equal vld_out AND (state in HDR/BODY) AND issued<total; never asserted when vld_out=0.
REQ-020 In HDR, total=1: exactly one read issued, then wait for header capture (cycle after read).
REQ-021 On header capture: pkt_addr, pkt_len registered; total=pkt_len+2; parity accumulator=header; state -> BODY.
REQ-022 BODY: each captured byte XORed into accumulator; captured count incremented; pkt_len=0 is legal (parity byte only).
REQ-023 When captured==total: state -> DONE; DONE asserts pkt_done, parity_err=(acc!=0), addr_err, increments pkt_count, -> IDLE next cycle.
REQ-024 Latency: last byte on data_out at cycle N -> pkt_done at cycle N+1.
REQ-025 Gap counter SHALL reset on each read, count cycles with vld_out=0 in HDR/BODY; reaching TMO -> trunc_err pulse, no pkt_done, pkt_count unchanged, -> IDLE.
REQ-026 parity_err/addr_err SHALL hold until next pkt_done or trunc_err (cleared on trunc_err).
REQ-027 vld_out falling in DLY SHALL return FSM to IDLE without reads.
REQ-028 Back-to-back packets: IDLE re-entered for one cycle minimum; next packet starts with DLY.

Reset
REQ-029 resetn=0 SHALL immediately force state IDLE, read_enb=0, pkt_done=0, trunc_err=0, parity_err=0, addr_err=0, pkt_addr=0, pkt_len=0, pkt_count=0, all internal counters 0.
REQ-030 Reset mid-packet SHALL discard partial packet; no pulses on release.

Structure
REQ-031 Shared package SHALL hold FSM state encoding, header field positions (LEN[7:2], ADDR[1:0]) and default TMO/START_DLY constants.
REQ-032 Single module; no sub-module required; all outputs registered except read_enb.

Verification
REQ-033 PORT_ID=2, header 8'h16 (len 5, addr 2), 5 payloads, correct parity -> 7 reads, pkt_done once, pkt_len=5, parity_err=0, addr_err=0, pkt_count=1.
REQ-034 PORT_ID=1, len 14 addr 1, parity byte inverted -> pkt_done, parity_err=1, pkt_count increments.
REQ-035 PORT_ID=0, header 8'h41 (len 16, addr 1) -> addr_err=1, 18 reads total, read_enb never high with vld_out=0.
REQ-036 vld_out held low 32 cycles after 3rd payload byte -> trunc_err pulse, no pkt_done, busy=0 next cycle.
REQ-037 resetn pulsed low mid-BODY -> read_enb=0 asynchronously, pkt_count=0; next full packet received correctly.
REQ-038 pkt_count preset near 16'hFFFF via 2 packets after forcing -> wraps to 0, header len 0 packet -> 2 reads, pkt_done.

Source files
------------

// File: rtl/router_pkt_sink_pkg.sv
// Shared definitions for the router packet sink: FSM encoding, header field layout and
// default timing constants.
package router_pkt_sink_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDly,
    StHdr,
    StBody,
    StDone
  } sink_state_e;

  localparam int unsigned LenMsb  = 7;
  localparam int unsigned LenLsb  = 2;
  localparam int unsigned AddrMsb = 1;
  localparam int unsigned AddrLsb = 0;

  localparam int unsigned DefaultStartDly = 2;
  localparam int unsigned DefaultTmo      = 32;

  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[LenMsb:LenLsb];
  endfunction

  function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[AddrMsb:AddrLsb];
  endfunction

endpackage

// File: rtl/router_pkt_sink.sv
// Drains one router output port: waits START_DLY cycles, reads header then body + parity,
// reports completion, parity/address errors, or truncation on a stalled FIFO.
module router_pkt_sink
  import router_pkt_sink_pkg::*;
#(
  parameter logic [1:0]  PORT_ID   = 2'd0,
  parameter int unsigned START_DLY = DefaultStartDly,
  parameter int unsigned TMO       = DefaultTmo
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        vld_out,
  input  logic [7:0]  data_out,
  output logic        read_enb,
  output logic        pkt_done,
  output logic [1:0]  pkt_addr,
  output logic [5:0]  pkt_len,
  output logic        parity_err,
  output logic        addr_err,
  output logic        trunc_err,
  output logic [15:0] pkt_count,
  output logic        busy
);

  localparam logic [7:0]  DlyLast = 8'(START_DLY > 0 ? START_DLY - 1 : 0);
  localparam logic [15:0] TmoLast = 16'(TMO > 0 ? TMO - 1 : 0);

  sink_state_e state_q, state_d;
  logic [7:0]  dly_q, dly_d;
  logic [15:0] gap_q, gap_d;
  logic [6:0]  issued_q, issued_d;
  logic [6:0]  captured_q, captured_d;
  logic [6:0]  total_q, total_d;
  logic [7:0]  acc_q, acc_d;
  logic        rd_q, rd_d;
  logic [1:0]  pkt_addr_q, pkt_addr_d;
  logic [5:0]  pkt_len_q, pkt_len_d;
  logic        parity_err_q, parity_err_d;
  logic        addr_err_q, addr_err_d;
  logic        pkt_done_q, pkt_done_d;
  logic        trunc_err_q, trunc_err_d;
  logic [15:0] pkt_count_q, pkt_count_d;

  logic in_pkt;
  logic timeout;

  always_comb begin
    in_pkt   = (state_q == StHdr) || (state_q == StBody);
    read_enb = vld_out && in_pkt && (issued_q < total_q);
    timeout  = !vld_out && (gap_q >= TmoLast);

    state_d      = state_q;
    dly_d        = dly_q;
    gap_d        = gap_q;
    issued_d     = issued_q;
    captured_d   = captured_q;
    total_d      = total_q;
    acc_d        = acc_q;
    rd_d         = read_enb;
    pkt_addr_d   = pkt_addr_q;
    pkt_len_d    = pkt_len_q;
    parity_err_d = parity_err_q;
    addr_err_d   = addr_err_q;
    pkt_done_d   = 1'b0;
    trunc_err_d  = 1'b0;
    pkt_count_d  = pkt_count_q;

    if (in_pkt) begin
      issued_d = issued_q + {6'd0, read_enb};
      if (read_enb) begin
        gap_d = '0;
      end else if (!vld_out) begin
        gap_d = gap_q + 16'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        dly_d      = '0;
        gap_d      = '0;
        issued_d   = '0;
        captured_d = '0;
        total_d    = 7'd1;
        if (vld_out) state_d = StDly;
      end
      StDly: begin
        if (!vld_out) begin
          state_d = StIdle;
        end else if (dly_q >= DlyLast) begin
          state_d = StHdr;
        end else begin
          dly_d = dly_q + 8'd1;
        end
      end
      StHdr: begin
        // Read data lands the cycle after the strobe, so rd_q marks a valid byte.
        if (rd_q) begin
          pkt_addr_d = hdr_addr(data_out);
          pkt_len_d  = hdr_len(data_out);
          total_d    = {1'b0, hdr_len(data_out)} + 7'd2;
          acc_d      = data_out;
          captured_d = 7'd1;
          state_d    = StBody;
        end else if (timeout) begin
          state_d      = StIdle;
          trunc_err_d  = 1'b1;
          parity_err_d = 1'b0;
          addr_err_d   = 1'b0;
        end
      end
      StBody: begin
        if (rd_q) begin
          acc_d      = acc_q ^ data_out;
          captured_d = captured_q + 7'd1;
          if (captured_q + 7'd1 == total_q) begin
            state_d      = StDone;
            pkt_done_d   = 1'b1;
            parity_err_d = (acc_q ^ data_out) != 8'd0;
            addr_err_d   = pkt_addr_q != PORT_ID;
            pkt_count_d  = pkt_count_q + 16'd1;
          end
        end else if (timeout) begin
          state_d      = StIdle;
          trunc_err_d  = 1'b1;
          parity_err_d = 1'b0;
          addr_err_d   = 1'b0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      dly_q        <= '0;
      gap_q        <= '0;
      issued_q     <= '0;
      captured_q   <= '0;
      total_q      <= '0;
      acc_q        <= '0;
      rd_q         <= 1'b0;
      pkt_addr_q   <= '0;
      pkt_len_q    <= '0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
      trunc_err_q  <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      gap_q        <= gap_d;
      issued_q     <= issued_d;
      captured_q   <= captured_d;
      total_q      <= total_d;
      acc_q        <= acc_d;
      rd_q         <= rd_d;
      pkt_addr_q   <= pkt_addr_d;
      pkt_len_q    <= pkt_len_d;
      parity_err_q <= parity_err_d;
      addr_err_q   <= addr_err_d;
      pkt_done_q   <= pkt_done_d;
      trunc_err_q  <= trunc_err_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign pkt_done   = pkt_done_q;
  assign pkt_addr   = pkt_addr_q;
  assign pkt_len    = pkt_len_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign trunc_err  = trunc_err_q;
  assign pkt_count  = pkt_count_q;
  assign busy       = (state_q != StIdle);

endmodule
